// File: rtl/alu_pipe_pkg.sv
// Shared types and helpers for alu_pipe: opcode enum, shifter FSM states,
// shift-mode selects and opcode classification functions.
package alu_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_SLTU  = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SR    = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_BEQ   = 4'b1000,
    ALU_BNE   = 4'b1001,
    ALU_ILL_A = 4'b1010,
    ALU_ILL_B = 4'b1011,
    ALU_BLT   = 4'b1100,
    ALU_BGE   = 4'b1101,
    ALU_BLTU  = 4'b1110,
    ALU_BGEU  = 4'b1111
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    SH_IDLE  = 2'd0,
    SH_SHIFT = 2'd1,
    SH_DONE  = 2'd2
  } shift_state_e;

  localparam logic [1:0] SH_SLL = 2'd0;
  localparam logic [1:0] SH_SRL = 2'd1;
  localparam logic [1:0] SH_SRA = 2'd2;

  function automatic logic is_illegal(input alu_ctrl_e c);
    return (c == ALU_ILL_A) || (c == ALU_ILL_B);
  endfunction

  function automatic logic is_branch(input alu_ctrl_e c);
    return c[3] && !is_illegal(c);
  endfunction

  function automatic logic is_shift(input alu_ctrl_e c);
    return (c == ALU_SLL) || (c == ALU_SR);
  endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Issue/result bus for alu_pipe. The ALU is the slave; issue logic and the
// writeback consumer together form the master side.
interface alu_pipe_if #(
  parameter int XLEN = 32
);
  // A transfer happens on a clock edge where valid && ready; valid may not
  // depend on ready, and the payload must stay stable while valid && !ready.
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [3:0]      in_ctrl;
  logic            in_sub;
  logic            in_arith;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] out_addr;
  logic            out_branch;
  logic            out_zf;
  logic            out_cf;
  logic            out_of;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_a, in_b, in_ctrl, in_sub, in_arith, out_ready,
    output in_ready, out_valid, out_result, out_addr, out_branch,
           out_zf, out_cf, out_of, out_illegal
  );

  modport master (
    output in_valid, in_a, in_b, in_ctrl, in_sub, in_arith, out_ready,
    input  in_ready, out_valid, out_result, out_addr, out_branch,
           out_zf, out_cf, out_of, out_illegal
  );
endinterface

// File: rtl/alu_pipe_shifter.sv
// Shift unit for alu_pipe. Combinational barrel shifter by default; with
// ALU_PIPE_ITER_SHIFT_EN defined, a 1-bit-per-cycle IDLE/SHIFT/DONE engine.
module alu_pipe_shifter
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            start,
  input  logic            drain,
  input  logic [XLEN-1:0] a,
  input  logic [SHW-1:0]  amt,
  input  logic [1:0]      mode,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output shift_state_e    state
);

`ifdef ALU_PIPE_ITER_SHIFT_EN

  shift_state_e    state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [1:0]      mode_q, mode_d;

  function automatic logic [XLEN-1:0] step1(input logic [XLEN-1:0] v,
                                            input logic [1:0] m);
    case (m)
      SH_SLL:  return {v[XLEN-2:0], 1'b0};
      SH_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
      default: return {1'b0, v[XLEN-1:1]};
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SH_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mode_q  <= SH_SLL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mode_q  <= mode_d;
    end
  end

  // DONE holds the result until drained; a new start may overlap the drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mode_d  = mode_q;
    case (state_q)
      SH_SHIFT: begin
        acc_d = step1(acc_q, mode_q);
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = SH_DONE;
      end
      default: begin
        if (start) begin
          acc_d   = a;
          mode_d  = mode;
          cnt_d   = amt;
          state_d = (amt == '0) ? SH_DONE : SH_SHIFT;
        end else if (state_q == SH_DONE && drain) begin
          state_d = SH_IDLE;
        end
      end
    endcase
  end

  assign busy   = (state_q == SH_SHIFT);
  assign done   = (state_q == SH_DONE);
  assign result = acc_q;
  assign state  = state_q;

`else

  logic unused_ok;
  assign unused_ok = ^{clock, reset_n, drain};

  always_comb begin
    case (mode)
      SH_SLL:  result = a << amt;
      SH_SRA:  result = $signed(a) >>> amt;
      default: result = a >> amt;
    endcase
  end

  assign busy  = 1'b0;
  assign done  = start;
  assign state = SH_IDLE;

`endif

endmodule

// File: rtl/alu_pipe.sv
// Handshaked single-issue ALU with a one-deep registered output stage.
// ALU_PIPE_ITER_SHIFT_EN selects the multi-cycle iterative shifter.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic         clock,
  input  logic         reset_n,
  alu_pipe_if.slave    bus,
  output shift_state_e dbg_state
);

  alu_ctrl_e       ctrl;
  logic            accept;
  logic            sub_eff;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum_ext;
  logic [XLEN-1:0] sum;
  logic            cf, of, zf, lt_s, lt_u;
  logic [XLEN-1:0] res_d;
  logic            br_d;
  logic [1:0]      sh_mode;
  logic            sh_busy, sh_done;
  logic [XLEN-1:0] sh_result;

  logic            live_q, valid_q;
  logic [XLEN-1:0] result_q, addr_q;
  logic            branch_q, zf_q, cf_q, of_q, illegal_q;

  assign ctrl   = alu_ctrl_e'(bus.in_ctrl);
  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    sub_eff = 1'b0;
    if (ctrl == ALU_SLT || ctrl == ALU_SLTU || is_branch(ctrl)) sub_eff = 1'b1;
    else if (ctrl == ALU_ADD)                                   sub_eff = bus.in_sub;
  end

  assign b_eff   = sub_eff ? ~bus.in_b : bus.in_b;
  assign sum_ext = {1'b0, bus.in_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub_eff};
  assign sum     = sum_ext[XLEN-1:0];
  assign cf      = sum_ext[XLEN];
  assign of      = (bus.in_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != bus.in_a[XLEN-1]);
  assign zf      = (sum == '0);
  assign lt_s    = of ^ sum[XLEN-1];
  assign lt_u    = ~cf;
  assign sh_mode = (ctrl == ALU_SLL) ? SH_SLL : (bus.in_arith ? SH_SRA : SH_SRL);

  alu_pipe_shifter #(.XLEN(XLEN)) u_shifter (
    .clock   (clock),
    .reset_n (reset_n),
    .start   (accept && is_shift(ctrl)),
    .drain   (bus.out_valid && bus.out_ready),
    .a       (bus.in_a),
    .amt     (bus.in_b[SHW-1:0]),
    .mode    (sh_mode),
    .busy    (sh_busy),
    .done    (sh_done),
    .result  (sh_result),
    .state   (dbg_state)
  );

  // Branches and illegal codes leave the result bus at zero.
  always_comb begin
    res_d = '0;
    br_d  = 1'b0;
    case (ctrl)
      ALU_ADD:         res_d = sum;
      ALU_SLL, ALU_SR: res_d = sh_result;
      ALU_SLT:         res_d = {{(XLEN-1){1'b0}}, lt_s};
      ALU_SLTU:        res_d = {{(XLEN-1){1'b0}}, lt_u};
      ALU_XOR:         res_d = bus.in_a ^ bus.in_b;
      ALU_OR:          res_d = bus.in_a | bus.in_b;
      ALU_AND:         res_d = bus.in_a & bus.in_b;
      ALU_BEQ:         br_d  = zf;
      ALU_BNE:         br_d  = ~zf;
      ALU_BLT:         br_d  = lt_s;
      ALU_BGE:         br_d  = ~lt_s;
      ALU_BLTU:        br_d  = lt_u;
      ALU_BGEU:        br_d  = ~lt_u;
      default:         res_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live_q    <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= '0;
      addr_q    <= '0;
      branch_q  <= 1'b0;
      zf_q      <= 1'b0;
      cf_q      <= 1'b0;
      of_q      <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (accept) begin
        valid_q   <= 1'b1;
        result_q  <= res_d;
        addr_q    <= bus.in_a + bus.in_b;
        branch_q  <= br_d;
        zf_q      <= zf;
        cf_q      <= cf;
        of_q      <= of;
        illegal_q <= is_illegal(ctrl);
      end else if (bus.out_valid && bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_PIPE_ITER_SHIFT_EN
  logic shift_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    shift_q <= 1'b0;
    else if (accept) shift_q <= is_shift(ctrl);
  end

  // A pending shift stays invisible until the shifter reaches DONE.
  assign bus.out_valid  = valid_q && (!shift_q || sh_done);
  assign bus.in_ready   = live_q && !sh_busy && (!bus.out_valid || bus.out_ready);
  assign bus.out_result = shift_q ? sh_result : result_q;
`else
  logic unused_sh;
  assign unused_sh = ^{sh_busy, sh_done};

  assign bus.out_valid  = valid_q;
  assign bus.in_ready   = live_q && (!valid_q || bus.out_ready);
  assign bus.out_result = result_q;
`endif

  assign bus.out_addr    = addr_q;
  assign bus.out_branch  = branch_q;
  assign bus.out_zf      = zf_q;
  assign bus.out_cf      = cf_q;
  assign bus.out_of      = of_q;
  assign bus.out_illegal = illegal_q;

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, handshaked successor to the core's single-issue ALU. Sits between decode/issue and writeback/LSU.
- Accepts one operation per valid/ready transfer, registers operands, and returns the result, flags, branch decision and LSU address through an output register with backpressure.
- Supports XLEN 32 or 64.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; do not override).

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept this cycle.
- in_a  in  XLEN  operand A (rs1/pc).
- in_b  in  XLEN  operand B (rs2/imm).
- in_ctrl  in  4  operation code (package enum).
- in_sub  in  1  ADD becomes SUB; ignored for other ops.
- in_arith  in  1  SR selects SRA when 1, SRL when 0.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_result  out  XLEN  operation result.
- out_addr  out  XLEN  in_a+in_b (never subtracted), for LSU.
- out_branch  out  1  branch taken.
- out_zf / out_cf / out_of  out  1 each  adder flags.
- out_illegal  out  1  unused opcode seen.

Behaviour:
- Opcodes:
  - ADD 0000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SR 0101, OR 0110, AND 0111.
  - BEQ 1000, BNE 1001, BLT 1100, BGE 1101, BLTU 1110, BGEU 1111.
  - 1010/1011 are illegal: result 0, branch 0, out_illegal 1.
- Adder:
  - sum = a + (sub ? ~b : b) + sub.
  - sub is forced to 1 for SLT, SLTU and all branches; otherwise sub = in_sub for ADD, else 0.
  - cf = carry out; of = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), where b' is the post-inversion operand; zf = (sum==0).
- Compare: lt_s = of ^ sum[MSB]; lt_u = ~cf.
  - SLT/SLTU result = {0..., lt}.
  - BEQ=zf, BNE=~zf, BLT=lt_s, BGE=~lt_s, BLTU=lt_u, BGEU=~lt_u.
  - Non-branch ops drive out_branch=0.
- Shifts use b[SHW-1:0] as the amount; SRA sign-fills; shift by 0 returns a.
- Pipeline (base mode):
  - Accept when in_valid && in_ready.
  - Latency 1: all outputs are registered and valid the cycle after acceptance.
  - in_ready = !out_valid || out_ready, which allows back-to-back full throughput.
- Output hold: while out_valid && !out_ready, every out_* stays stable and in_ready is 0.
- out_valid falls only when out_ready is high and there is no new accept in the same cycle. A simultaneous drain and accept loads the new result with out_valid staying 1.
- Flags:
  - out_zf/cf/of always reflect the adder of the accepted op (including logic ops).
  - For shifts they reflect the unsubtracted sum.
- Reset (async, any time including mid-operation):
  - out_valid=0, out_* data=0, out_illegal=0.
  - Iterative state returns to IDLE; in_ready rises on the first clock after deassertion.
- in_ctrl/in_a/in_b are sampled only on accept; changes without a handshake are ignored.

Optional Feature:
- Macro: ALU_PIPE_ITER_SHIFT_EN.
- Defined: shifts execute in a 1-bit/cycle iterative shifter.
  - FSM IDLE -> SHIFT -> DONE.
  - On accepting a shift with amount n>0, enter SHIFT and decrement a counter from n; shift one bit per cycle.
  - n=0 goes directly to DONE.
  - DONE asserts out_valid with result. Latency = max(n,1) cycles after accept.
  - in_ready is 0 in SHIFT and in DONE until drained.
  - Non-shift ops keep latency 1.
- Undefined: single-cycle barrel shifter; no FSM, latency always 1.

Decomposition:
- Package alu_pipe_pkg:
  - alu_ctrl_e enum holding the 16 codes above.
  - Helper functions is_branch() and is_shift().
  - Shift-select localparams SLL/SRL/SRA.
- Sub-module alu_pipe_shifter:
  - Barrel or iterative implementation, selected by the macro.
  - Interface: start, a, amt, mode, busy, done, result.
  - Parametrised by XLEN.

Test Plan:
- XLEN=32: ADD a=0x7FFFFFFF, b=1, sub=0 -> result 0x80000000, of=1, cf=0, zf=0, out_valid one cycle after accept.
- SUB a=5, b=5 -> result 0, zf=1, cf=1. BEQ same operands -> branch=1. BLTU a=1, b=0xFFFFFFFF -> branch=1. BLT same operands -> branch=0.
- SRA a=0x80000000 amt=31 -> 0xFFFFFFFF; SRL -> 0x00000001. XLEN=64 SLL a=1 amt=63 -> 0x8000000000000000.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable. Then out_ready=1 with a new op -> drain and load in the same cycle, no bubble, no loss.
- Iterative build: SLL amt=5 -> out_valid exactly 5 cycles after accept, in_ready=0 throughout. Assert reset_n low mid-SHIFT -> out_valid=0 immediately; the next op completes normally.
- in_ctrl=1010 -> result 0, branch 0, out_illegal=1. A following legal op clears out_illegal.
